// File: rtl/ifm_buf_read_ctrl_pkg.sv
// ifm_buf_read_ctrl_pkg
// Shared definitions for the IFM ping-pong buffer read controller.
//   - lane geometry of the 64-bit buffer word (8 lanes x 8 bit)
//   - layout of the skid payload (data plus sol/eol/last tags)
//   - read FSM state encoding
//   - helper to pack one beat into the skid payload
package ifm_buf_read_ctrl_pkg;

    localparam int IFM_LANES     = 8;
    localparam int IFM_LANE_W    = 8;
    localparam int IFM_DATA_W    = IFM_LANES * IFM_LANE_W;
    localparam int IFM_TAG_W     = 3;
    localparam int IFM_PAYLOAD_W = IFM_DATA_W + IFM_TAG_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_t;

    // Payload layout: {data, sol, eol, last}, last in bit 0.
    function automatic logic [IFM_PAYLOAD_W-1:0] pack_beat(
        input logic [IFM_DATA_W-1:0] data,
        input logic                  sol,
        input logic                  eol,
        input logic                  last
    );
        return {data, sol, eol, last};
    endfunction

endpackage

// File: rtl/ifm_buf_read_ctrl_if.sv
// ifm_buf_read_ctrl_if
// Ready/valid beat stream from the IFM read controller to the
// line-buffer / PE array.
//   m_data  : 64-bit beat, lane k in [8k+7:8k]
//   m_valid : beat valid
//   m_ready : downstream accept
//   m_sol   : beat is column 0
//   m_eol   : beat is column W-1
//   m_last  : final beat of the tile
// master = read controller, slave = consumer.
interface ifm_buf_read_ctrl_if;
    import ifm_buf_read_ctrl_pkg::*;

    logic [IFM_DATA_W-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;
    logic                  m_sol;
    logic                  m_eol;
    logic                  m_last;

    modport master (
        output m_data, m_valid, m_sol, m_eol, m_last,
        input  m_ready
    );

    modport slave (
        input  m_data, m_valid, m_sol, m_eol, m_last,
        output m_ready
    );

endinterface

// File: rtl/ifm_buf_read_ctrl_skid2.sv
// ifm_rd_skid2
// Two-entry FIFO that catches buffer read data (one cycle after the
// address) together with its tags, so the address issue stage can keep
// running while the consumer stalls.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write push_data this cycle (caller guarantees room)
//   push_data  : payload to store
//   pop        : remove head this cycle (caller guarantees non-empty)
//   head       : oldest stored payload
//   count      : number of stored entries (0..2)
module ifm_rd_skid2 #(
    parameter int WIDTH = 67
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] entry0;
    logic [WIDTH-1:0] entry1;
    logic             wr_ptr;
    logic             rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry0 <= '0;
            entry1 <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                if (wr_ptr) begin
                    entry1 <= push_data;
                end else begin
                    entry0 <= push_data;
                end
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head = rd_ptr ? entry1 : entry0;

endmodule

// File: rtl/ifm_buf_read_ctrl.sv
// ifm_buf_read_ctrl
// Read-side controller for the ping-pong IFM buffer. It owns the bank
// select, swaps banks when the writer has filled one and the reader is
// free, sweeps a W x H x G tile out of the readable bank (~buf_sel) and
// returns the data as a tagged ready/valid stream.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   cfg_width/height  : tile columns W / rows H (latched at swap)
//   cfg_groups        : channel groups G (latched at swap)
//   fill_done         : writer finished bank buf_sel (1-cycle pulse)
//   wr_bank_free      : writer may fill bank buf_sel
//   buf_sel           : write bank select; reader uses ~buf_sel
//   bram_addr_read    : per-bank read address (registered)
//   ram_dout          : read data, valid the cycle after the address
//   m_if              : beat stream (data, valid/ready, sol/eol/last)
//   frame_done        : pulse once the whole tile has been delivered
//   busy              : reader not idle
//   ovf_err           : sticky, a fill_done arrived while one was pending
module ifm_buf_read_ctrl
    import ifm_buf_read_ctrl_pkg::*;
#(
    parameter int ADDR_BIT = 15,
    parameter int W_BIT    = 8,
    parameter int G_BIT    = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [W_BIT-1:0]       cfg_width,
    input  logic [W_BIT-1:0]       cfg_height,
    input  logic [G_BIT-1:0]       cfg_groups,
    input  logic                   fill_done,
    output logic                   wr_bank_free,
    output logic                   buf_sel,
    output logic [ADDR_BIT-2:0]    bram_addr_read,
    input  logic [IFM_DATA_W-1:0]  ram_dout,
    ifm_buf_read_ctrl_if.master    m_if,
    output logic                   frame_done,
    output logic                   busy,
    output logic                   ovf_err
);

    localparam int AW = ADDR_BIT - 1;

    rd_state_t state;
    rd_state_t state_next;

    logic              fill_pend;
    logic [W_BIT-1:0]  w_q;
    logic [W_BIT-1:0]  h_q;
    logic [G_BIT-1:0]  g_q;
    logic [W_BIT-1:0]  col;
    logic [W_BIT-1:0]  row;
    logic [G_BIT-1:0]  grp;

    logic              inflight;
    logic              inflight_sol;
    logic              inflight_eol;
    logic              inflight_last;

    logic              swap;
    logic              issue;
    logic              cfg_zero;
    logic              col_max;
    logic              row_max;
    logic              grp_max;
    logic              is_last;
    logic              issue_ok;
    logic              pop;
    logic              skid_valid;
    logic [1:0]        skid_count;
    logic [2:0]        occ_sum;
    logic [IFM_PAYLOAD_W-1:0] push_data;
    logic [IFM_PAYLOAD_W-1:0] head;

    assign wr_bank_free = ~fill_pend;

    // A zero dimension still swaps but produces no beats; the FSM then
    // goes straight to DRAIN so frame_done follows on the next cycle.
    assign cfg_zero = (cfg_width == '0) || (cfg_height == '0) || (cfg_groups == '0);

    assign col_max = (col == w_q - W_BIT'(1));
    assign row_max = (row == h_q - W_BIT'(1));
    assign grp_max = (grp == g_q - G_BIT'(1));
    assign is_last = col_max && row_max && grp_max;

    assign skid_valid = (skid_count != 2'd0);
    assign pop        = skid_valid && m_if.m_ready;

    // The skid has two slots; a new address is only issued when the data
    // it returns next cycle is guaranteed a slot.
    assign occ_sum  = {1'b0, skid_count} + {2'b00, inflight} - {2'b00, pop};
    assign issue_ok = (occ_sum <= 3'd1);

    // Next-state and per-cycle strobes.
    always_comb begin
        state_next = state;
        swap       = 1'b0;
        issue      = 1'b0;
        frame_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (fill_pend) begin
                    swap       = 1'b1;
                    state_next = cfg_zero ? ST_DRAIN : ST_READ;
                end
            end
            ST_READ: begin
                if (issue_ok) begin
                    issue = 1'b1;
                    if (is_last) begin
                        state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!inflight && !skid_valid) begin
                    frame_done = 1'b1;
                    if (fill_pend) begin
                        swap       = 1'b1;
                        state_next = cfg_zero ? ST_DRAIN : ST_READ;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register; busy is a registered copy of (state != IDLE).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != ST_IDLE);
        end
    end

    // Pending-fill flag and overflow. The flag is still set during the swap
    // cycle, so a fill_done landing there is dropped and flagged too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_pend <= 1'b0;
            ovf_err   <= 1'b0;
        end else begin
            if (fill_done && fill_pend) begin
                ovf_err <= 1'b1;
            end
            if (swap) begin
                fill_pend <= 1'b0;
            end else if (fill_done) begin
                fill_pend <= 1'b1;
            end
        end
    end

    // Bank select and tile geometry latched at each swap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_sel <= 1'b0;
            w_q     <= '0;
            h_q     <= '0;
            g_q     <= '0;
        end else if (swap) begin
            buf_sel <= ~buf_sel;
            w_q     <= cfg_width;
            h_q     <= cfg_height;
            g_q     <= cfg_groups;
        end
    end

    // Sweep counters and linear read address. The address register is the
    // address presented this cycle; it advances only when it is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col            <= '0;
            row            <= '0;
            grp            <= '0;
            bram_addr_read <= '0;
        end else if (swap) begin
            col            <= '0;
            row            <= '0;
            grp            <= '0;
            bram_addr_read <= '0;
        end else if (issue) begin
            bram_addr_read <= bram_addr_read + AW'(1);
            if (col_max) begin
                col <= '0;
                if (row_max) begin
                    row <= '0;
                    grp <= grp + G_BIT'(1);
                end else begin
                    row <= row + W_BIT'(1);
                end
            end else begin
                col <= col + W_BIT'(1);
            end
        end
    end

    // Tags follow their address through the one-cycle RAM latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight      <= 1'b0;
            inflight_sol  <= 1'b0;
            inflight_eol  <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_sol  <= (col == '0);
                inflight_eol  <= col_max;
                inflight_last <= is_last;
            end
        end
    end

    assign push_data = pack_beat(ram_dout, inflight_sol, inflight_eol, inflight_last);

    ifm_rd_skid2 #(
        .WIDTH (IFM_PAYLOAD_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (skid_count)
    );

    assign m_if.m_valid = skid_valid;
    assign m_if.m_data  = head[IFM_PAYLOAD_W-1:IFM_TAG_W];
    assign m_if.m_sol   = head[2];
    assign m_if.m_eol   = head[1];
    assign m_if.m_last  = head[0];

endmodule

// File: tb/tb_ifm_buf_read_ctrl.sv
// tb_ifm_buf_read_ctrl
// Self-checking bench for ifm_buf_read_ctrl. A behavioural RAM returns a
// known word per (bank, address); a stream monitor predicts every beat of
// a tile from the tile geometry and the number of tiles since reset.
module tb_ifm_buf_read_ctrl;
    import ifm_buf_read_ctrl_pkg::*;

    localparam int ADDR_BIT = 15;
    localparam int W_BIT    = 8;
    localparam int G_BIT    = 2;
    localparam int AW       = ADDR_BIT - 1;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [W_BIT-1:0]      cfg_width = '0;
    logic [W_BIT-1:0]      cfg_height = '0;
    logic [G_BIT-1:0]      cfg_groups = '0;
    logic                  fill_done = 1'b0;
    logic                  wr_bank_free;
    logic                  buf_sel;
    logic [ADDR_BIT-2:0]   bram_addr_read;
    logic [IFM_DATA_W-1:0] ram_dout = '0;
    logic                  frame_done;
    logic                  busy;
    logic                  ovf_err;

    ifm_buf_read_ctrl_if s_if();

    ifm_buf_read_ctrl #(
        .ADDR_BIT (ADDR_BIT),
        .W_BIT    (W_BIT),
        .G_BIT    (G_BIT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_width      (cfg_width),
        .cfg_height     (cfg_height),
        .cfg_groups     (cfg_groups),
        .fill_done      (fill_done),
        .wr_bank_free   (wr_bank_free),
        .buf_sel        (buf_sel),
        .bram_addr_read (bram_addr_read),
        .ram_dout       (ram_dout),
        .m_if           (s_if),
        .frame_done     (frame_done),
        .busy           (busy),
        .ovf_err        (ovf_err)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] salt = 32'h0;
    int          ready_mode = 0;
    int          ready_phase = 0;
    int          beat_idx = 0;
    int          tiles_seen = 0;
    int          frame_cnt = 0;
    int          total_beats = 0;
    logic        stall_prev = 1'b0;
    logic [IFM_PAYLOAD_W-1:0] prev_beat = '0;

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [63:0] data_of(input logic bank, input int unsigned a);
        logic [31:0] x;
        x = (a * 32'h9E3779B1) ^ salt;
        return {x ^ {bank, 31'd0}, ~x + a};
    endfunction

    // Buffer RAM: registered read of the readable bank.
    always @(posedge clk) begin
        ram_dout <= data_of(~buf_sel, bram_addr_read);
    end

    // Downstream ready: 0 = always ready, 1 = 1,0,0,1 pattern, 2 = random.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: s_if.m_ready = 1'b1;
            1: begin
                s_if.m_ready = ((ready_phase % 4) == 0) || ((ready_phase % 4) == 3);
                ready_phase++;
            end
            default: s_if.m_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Stream monitor: beat k of a tile sits at address k mod 2^AW of the
    // bank read for that tile; tiles alternate bank 0, 1, 0, ... after reset.
    always @(negedge clk) begin
        int n;
        int w;
        logic bank;
        if (!rst_n) begin
            beat_idx   = 0;
            tiles_seen = 0;
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                checkOutput("hold_valid", s_if.m_valid, 1);
                checkOutput("hold_beat", {s_if.m_data, s_if.m_sol, s_if.m_eol, s_if.m_last}, prev_beat);
            end
            if (s_if.m_valid && s_if.m_ready) begin
                w = int'(cfg_width);
                n = w * int'(cfg_height) * int'(cfg_groups);
                if (n == 0) begin
                    checkOutput("unexpected_beat", 1, 0);
                end else begin
                    if (beat_idx == 0) tiles_seen++;
                    bank = ((tiles_seen % 2) == 1) ? 1'b0 : 1'b1;
                    checkOutput("beat_data", s_if.m_data, data_of(bank, beat_idx % (1 << AW)));
                    checkOutput("beat_sol", s_if.m_sol, (beat_idx % w) == 0);
                    checkOutput("beat_eol", s_if.m_eol, (beat_idx % w) == (w - 1));
                    checkOutput("beat_last", s_if.m_last, beat_idx == (n - 1));
                    beat_idx++;
                    if (beat_idx >= n) beat_idx = 0;
                end
                total_beats++;
            end
            if (frame_done) begin
                frame_cnt++;
                checkOutput("frame_after_last_beat", beat_idx == 0, 1);
            end
            stall_prev = s_if.m_valid && !s_if.m_ready;
            prev_beat  = {s_if.m_data, s_if.m_sol, s_if.m_eol, s_if.m_last};
        end
    end

    task automatic checkResetState();
        checkOutput("rst_buf_sel", buf_sel, 0);
        checkOutput("rst_addr", bram_addr_read, 0);
        checkOutput("rst_valid", s_if.m_valid, 0);
        checkOutput("rst_sol", s_if.m_sol, 0);
        checkOutput("rst_eol", s_if.m_eol, 0);
        checkOutput("rst_last", s_if.m_last, 0);
        checkOutput("rst_data", s_if.m_data, 0);
        checkOutput("rst_frame_done", frame_done, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_ovf", ovf_err, 0);
        checkOutput("rst_wr_bank_free", wr_bank_free, 1);
    endtask

    task automatic resetDut();
        rst_n     = 1'b0;
        fill_done = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic applyStimulus(input int w, input int h, input int g);
        cfg_width  = W_BIT'(w);
        cfg_height = W_BIT'(h);
        cfg_groups = G_BIT'(g);
        @(posedge clk);
        #1 fill_done = 1'b1;
        @(posedge clk);
        #1 fill_done = 1'b0;
    endtask

    task automatic waitFrames(input int target, input int budget);
        int c = 0;
        while (frame_cnt < target && c < budget) begin
            @(negedge clk);
            c++;
        end
        checkOutput("wait_frames_timeout", frame_cnt >= target, 1);
    endtask

    // Cycle-accurate check of one tile from IDLE with m_ready held high:
    // fill_done in cycle 0, swap at end of cycle 1, addresses from cycle 2,
    // beats from cycle 4, frame_done the cycle after the last beat.
    task automatic checkTimeline(input int w, input int h, input int g, input logic bs0);
        int   n;
        int   last_k;
        logic e_sel;
        logic e_fd;
        logic e_busy;
        logic e_valid;
        ready_mode = 0;
        cfg_width  = W_BIT'(w);
        cfg_height = W_BIT'(h);
        cfg_groups = G_BIT'(g);
        n      = w * h * g;
        last_k = (n == 0) ? 6 : n + 6;
        @(posedge clk);
        #1 fill_done = 1'b1;
        for (int k = 0; k < last_k; k++) begin
            @(negedge clk);
            e_sel   = (k >= 2) ? !bs0 : bs0;
            e_fd    = (n == 0) ? (k == 2) : (k == n + 4);
            e_busy  = (n == 0) ? (k == 2) : (k >= 2 && k <= n + 4);
            e_valid = (n > 0) && (k >= 4) && (k <= n + 3);
            checkOutput("tl_buf_sel", buf_sel, e_sel);
            checkOutput("tl_frame_done", frame_done, e_fd);
            checkOutput("tl_busy", busy, e_busy);
            checkOutput("tl_valid", s_if.m_valid, e_valid);
            checkOutput("tl_wr_bank_free", wr_bank_free, k != 1);
            if (n > 0 && k >= 2 && k <= n + 1)
                checkOutput("tl_addr", bram_addr_read, (k - 2) % (1 << AW));
            @(posedge clk);
            #1 fill_done = 1'b0;
        end
    endtask

    initial begin
        int base_beats;
        int base_frames;
        int c;
        int lf;
        int it;
        int idle_cycles;
        int rw, rh, rg;

        salt          = $urandom;
        s_if.m_ready  = 1'b1;
        rst_n         = 1'b0;
        repeat (2) @(posedge clk);
        #1 checkResetState();
        #1 rst_n = 1'b1;

        // Basic 3x2x1 tile, full throughput, exact cycle timing.
        base_beats = total_beats;
        checkTimeline(3, 2, 1, 1'b0);
        checkOutput("t1_beats", total_beats - base_beats, 6);

        // Same tile with ready pattern 1,0,0,1; bank flips back to 0.
        ready_phase = 0;
        ready_mode  = 1;
        base_beats  = total_beats;
        base_frames = frame_cnt;
        applyStimulus(3, 2, 1);
        waitFrames(base_frames + 1, 300);
        checkOutput("t2_beats", total_beats - base_beats, 6);
        checkOutput("t2_buf_sel", buf_sel, 0);
        ready_mode = 0;

        // Zero width: swap, no beats, frame_done on the cycle after swap.
        resetDut();
        base_beats = total_beats;
        checkTimeline(0, 2, 1, 1'b0);
        checkOutput("t5_beats", total_beats - base_beats, 0);

        // Two fill_done pulses without a swap in between (second lands in
        // the swap cycle): overflow flagged, only one swap.
        resetDut();
        base_frames = frame_cnt;
        cfg_width  = 8'd2;
        cfg_height = 8'd1;
        cfg_groups = 2'd1;
        @(posedge clk);
        #1 fill_done = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 fill_done = 1'b0;
        waitFrames(base_frames + 1, 100);
        repeat (10) @(negedge clk);
        checkOutput("t4_ovf", ovf_err, 1);
        checkOutput("t4_buf_sel", buf_sel, 1);
        checkOutput("t4_frames", frame_cnt - base_frames, 1);
        checkOutput("t4_busy", busy, 0);
        checkOutput("t4_wr_bank_free", wr_bank_free, 1);
        repeat (20) @(negedge clk);
        checkOutput("t4_ovf_sticky", ovf_err, 1);

        // Reset while beat 3 is presented, then restart cleanly.
        resetDut();
        base_beats = total_beats;
        applyStimulus(3, 2, 1);
        c = 0;
        do begin
            @(posedge clk);
            #2;
            c++;
        end while (total_beats - base_beats < 3 && c < 100);
        checkOutput("t6_reach_beat3", total_beats - base_beats, 3);
        rst_n = 1'b0;
        #1 checkResetState();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        base_beats = total_beats;
        checkTimeline(3, 2, 1, 1'b0);
        checkOutput("t6_restart_beats", total_beats - base_beats, 6);

        // Random geometry, random backpressure, back-to-back fills.
        for (int r = 0; r < 3; r++) begin
            resetDut();
            ready_mode  = 2;
            rw = $urandom_range(1, 6);
            rh = $urandom_range(1, 4);
            rg = $urandom_range(1, 3);
            cfg_width   = W_BIT'(rw);
            cfg_height  = W_BIT'(rh);
            cfg_groups  = G_BIT'(rg);
            base_beats  = total_beats;
            base_frames = frame_cnt;
            for (int t = 0; t < 3; t++) begin
                repeat ($urandom_range(0, 15)) @(posedge clk);
                c = 0;
                @(posedge clk);
                #1;
                while (!wr_bank_free && c < 500) begin
                    @(posedge clk);
                    #1;
                    c++;
                end
                checkOutput("rnd_writer_wait", wr_bank_free, 1);
                fill_done = 1'b1;
                @(posedge clk);
                #1 fill_done = 1'b0;
            end
            waitFrames(base_frames + 3, 3000);
            checkOutput("rnd_beats", total_beats - base_beats, 3 * rw * rh * rg);
            checkOutput("rnd_buf_sel", buf_sel, 1);
            checkOutput("rnd_ovf", ovf_err, 0);
        end
        ready_mode = 0;

        // Large tile with a second fill mid-READ: direct swap, no IDLE gap,
        // address wraps past 2^14.
        resetDut();
        base_beats  = total_beats;
        applyStimulus(114, 114, 2);
        lf          = 0;
        it          = 0;
        idle_cycles = 0;
        while (lf < 2 && it < 60000) begin
            @(negedge clk);
            it++;
            if (frame_done) lf++;
            if (it == 1000) fill_done = 1'b1;
            if (it == 1001) fill_done = 1'b0;
            if (it == 1005) checkOutput("t3_pend_blocks_writer", wr_bank_free, 0);
            if (it >= 2 && lf < 2 && !busy) idle_cycles++;
        end
        checkOutput("t3_frames", lf, 2);
        checkOutput("t3_idle_gap", idle_cycles, 0);
        checkOutput("t3_beats", total_beats - base_beats, 2 * 25992);
        checkOutput("t3_buf_sel", buf_sel, 0);
        checkOutput("t3_wr_bank_free", wr_bank_free, 1);
        checkOutput("t3_ovf", ovf_err, 0);
        @(negedge clk);
        checkOutput("t3_busy_falls", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
